// File: rtl/cmp_pkg.sv
// Shared types for the sequential magnitude comparator: predicate encoding,
// FSM states and the predicate-selection helper.
package cmp_pkg;

  typedef enum logic [1:0] {
    CMP_EQ = 2'b00,
    CMP_NE = 2'b01,
    CMP_LT = 2'b10,
    CMP_GE = 2'b11
  } cmp_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Maps the magnitude flags onto the requested predicate.
  function automatic logic cmp_pred(cmp_op_e op, logic lt, logic eq);
    logic r;
    case (op)
      CMP_EQ:  r = eq;
      CMP_NE:  r = !eq;
      CMP_LT:  r = lt;
      default: r = !lt;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/digit_cmp.sv
// Unsigned magnitude compare of one DIGIT-bit chunk; purely combinational.
module digit_cmp #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  output logic             lt,
  output logic             gt,
  output logic             eq
);

  assign lt = (a < b);
  assign gt = (a > b);
  assign eq = (a == b);

endmodule

// File: rtl/seq_comparator.sv
// Digit-serial magnitude comparator. Operands are latched on accept and
// compared one DIGIT-bit chunk per cycle from the MSB end, stopping at the
// first differing chunk. Signed compares are turned into unsigned ones by
// flipping both sign bits at latch time.
//
// state   | meaning
// IDLE    | waiting for a request, in_ready high
// BUSY    | comparing the top chunk of the shift registers
// DONE    | result presented, waiting for out_ready
module seq_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             signed_mode,
  input  logic [1:0]       cmp_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             lt,
  output logic             gt,
  output logic             eq,
  output logic             result
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N + 1);

  if (WIDTH % DIGIT != 0) begin : g_bad_width
    $error("seq_comparator: WIDTH must be a multiple of DIGIT");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  cmp_op_e          cmp_op_q, cmp_op_d;
  logic             lt_q, lt_d;
  logic             gt_q, gt_d;
  logic             eq_q, eq_d;

  logic             d_lt, d_gt, d_eq;

  digit_cmp #(.DIGIT(DIGIT)) u_digit_cmp (
    .a  (a_q[WIDTH-1 -: DIGIT]),
    .b  (b_q[WIDTH-1 -: DIGIT]),
    .lt (d_lt),
    .gt (d_gt),
    .eq (d_eq)
  );

  // Next-state, datapath shift and flag capture.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    cmp_op_d = cmp_op_q;
    lt_d     = lt_q;
    gt_d     = gt_q;
    eq_d     = eq_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d      = op_a ^ {signed_mode, {(WIDTH-1){1'b0}}};
          b_d      = op_b ^ {signed_mode, {(WIDTH-1){1'b0}}};
          cmp_op_d = cmp_op_e'(cmp_op);
          cnt_d    = '0;
          lt_d     = 1'b0;
          gt_d     = 1'b0;
          eq_d     = 1'b0;
          state_d  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (d_lt) begin
          lt_d    = 1'b1;
          state_d = ST_DONE;
        end else if (d_gt) begin
          gt_d    = 1'b1;
          state_d = ST_DONE;
        end else begin
          a_d = a_q << DIGIT;
          b_d = b_q << DIGIT;
          // d_eq holds here; the last chunk matching means full equality
          if (d_eq && cnt_q == CW'(N - 1)) begin
            eq_d    = 1'b1;
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          lt_d    = 1'b0;
          gt_d    = 1'b0;
          eq_d    = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      cmp_op_q <= CMP_EQ;
      lt_q     <= 1'b0;
      gt_q     <= 1'b0;
      eq_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      cmp_op_q <= cmp_op_d;
      lt_q     <= lt_d;
      gt_q     <= gt_d;
      eq_q     <= eq_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE) && !rst;
  assign out_valid = (state_q == ST_DONE);
  assign lt        = lt_q;
  assign gt        = gt_q;
  assign eq        = eq_q;
  // NE/GE would read 1 with all flags clear, so gate by DONE
  assign result    = out_valid && cmp_pred(cmp_op_q, lt_q, eq_q);

endmodule

// File: tb/tb_seq_comparator.sv
// Directed bench for seq_comparator (WIDTH=16, DIGIT=4) with a scoreboard of
// expected flags, predicate value and latency.
module tb_seq_comparator;

  localparam int WIDTH = 16;
  localparam int DIGIT = 4;
  localparam int N     = WIDTH / DIGIT;
  localparam int BUDGET = 20;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a, op_b;
  logic             signed_mode;
  logic [1:0]       cmp_op;
  logic             out_valid;
  logic             out_ready;
  logic             lt, gt, eq, result;

  seq_comparator #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .signed_mode (signed_mode),
    .cmp_op      (cmp_op),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .lt          (lt),
    .gt          (gt),
    .eq          (eq),
    .result      (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic lt;
    logic gt;
    logic eq;
    logic res;
    int   lat;
  } exp_t;

  exp_t sb[$];
  exp_t last_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Reference: whole-word compare plus first differing chunk for latency.
  function automatic exp_t model(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b,
                                 logic sm, logic [1:0] op);
    exp_t e;
    logic [WIDTH-1:0] x;
    e.lt  = sm ? ($signed(a) < $signed(b)) : (a < b);
    e.eq  = (a == b);
    e.gt  = !e.lt && !e.eq;
    case (op)
      2'b00:   e.res = e.eq;
      2'b01:   e.res = !e.eq;
      2'b10:   e.res = e.lt;
      default: e.res = !e.lt;
    endcase
    x = a ^ b;
    e.lat = N;
    for (int k = N; k >= 1; k--)
      if (x[WIDTH-1-(k-1)*DIGIT -: DIGIT] != '0) e.lat = k;
    return e;
  endfunction

  task automatic drive(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic sm, input logic [1:0] op, input bit push);
    int w = 0;
    while (!in_ready && w < BUDGET) begin
      @(posedge clk); #1; w++;
    end
    chk("in_ready_wait", {31'b0, in_ready}, 32'd1);
    op_a = a; op_b = b; signed_mode = sm; cmp_op = op; in_valid = 1'b1;
    if (push) sb.push_back(model(a, b, sm, op));
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 0;
  endtask

  task automatic collect();
    while (!out_valid && cyc < BUDGET) step();
    chk("out_valid_timeout", {31'b0, out_valid}, 32'd1);
    last_e = sb.pop_front();
    chk("latency", cyc, last_e.lat);
    chk("lt", {31'b0, lt}, {31'b0, last_e.lt});
    chk("gt", {31'b0, gt}, {31'b0, last_e.gt});
    chk("eq", {31'b0, eq}, {31'b0, last_e.eq});
    chk("result", {31'b0, result}, {31'b0, last_e.res});
    chk("in_ready_done", {31'b0, in_ready}, 32'd0);
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("out_valid_cleared", {31'b0, out_valid}, 32'd0);
    chk("flags_cleared", {28'b0, lt, gt, eq, result}, 32'd0);
    chk("in_ready_idle", {31'b0, in_ready}, 32'd1);
  endtask

  task automatic run(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                     input logic sm, input logic [1:0] op);
    drive(a, b, sm, op, 1'b1);
    collect();
    release_result();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; op_a = '0; op_b = '0;
    signed_mode = 1'b0; cmp_op = 2'b00; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_flags", {28'b0, lt, gt, eq, result}, 32'd0);
    rst = 1'b0;
    #1;
    chk("in_ready_after_rst", {31'b0, in_ready}, 32'd1);

    // directed vectors
    run(16'h1234, 16'h1234, 1'b0, 2'b00);
    run(16'h8000, 16'h7FFF, 1'b0, 2'b10);
    run(16'h8000, 16'h7FFF, 1'b1, 2'b10);
    run(16'h00F0, 16'h00F1, 1'b0, 2'b11);
    run(16'hFFFF, 16'h0001, 1'b1, 2'b11);
    run(16'h1235, 16'h1234, 1'b0, 2'b01);
    run(16'h1200, 16'h1300, 1'b1, 2'b00);
    run(16'h0A00, 16'h0A00, 1'b1, 2'b01);
    for (int i = 0; i < 6; i++)
      run(16'($urandom), 16'($urandom), 1'($urandom), 2'($urandom));

    // backpressure, with an ignored request and input changes during BUSY
    out_ready = 1'b0;
    drive(16'h5A5A, 16'h5A5A, 1'b0, 2'b00, 1'b1);
    in_valid = 1'b1; op_a = 16'h0001; op_b = 16'hFFFF; cmp_op = 2'b10;
    step();
    in_valid = 1'b0;
    chk("busy_in_ready", {31'b0, in_ready}, 32'd0);
    collect();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_out_valid", {31'b0, out_valid}, 32'd1);
      chk("hold_flags", {28'b0, lt, gt, eq, result},
          {28'b0, last_e.lt, last_e.gt, last_e.eq, last_e.res});
      chk("hold_in_ready", {31'b0, in_ready}, 32'd0);
    end
    release_result();

    // reset in the 2nd BUSY cycle abandons the operation
    drive(16'h4444, 16'h4444, 1'b0, 2'b00, 1'b0);
    step();
    rst = 1'b1;
    step();
    chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
    chk("abort_in_ready_rst", {31'b0, in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("abort_in_ready", {31'b0, in_ready}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("abort_no_result", {31'b0, out_valid}, 32'd0);
    end
    run(16'h00F0, 16'h00F1, 1'b0, 2'b11);

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
